// File: rtl/demux_n_1_2_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one producer-side stream,
// two consumer-side streams and the per-output transfer counters.
interface demux_n_1_2_if #(
  parameter int N  = 8,
  parameter int CW = 16
);
  logic [N-1:0]  in_0;
  logic          sel;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out_y_0;
  logic          out_valid_0;
  logic          out_ready_0;
  logic [N-1:0]  out_y_1;
  logic          out_valid_1;
  logic          out_ready_1;
  logic [CW-1:0] xfer_cnt_0;
  logic [CW-1:0] xfer_cnt_1;

  modport slave (
    input  in_0, sel, in_valid, out_ready_0, out_ready_1,
    output in_ready, out_y_0, out_valid_0, out_y_1, out_valid_1,
           xfer_cnt_0, xfer_cnt_1
  );

  modport master (
    output in_0, sel, in_valid, out_ready_0, out_ready_1,
    input  in_ready, out_y_0, out_valid_0, out_y_1, out_valid_1,
           xfer_cnt_0, xfer_cnt_1
  );
endinterface

// File: rtl/demux_n_1_2.sv
// 1-to-2 valid/ready stream demultiplexer; each output has a 2-entry FIFO
// and a wrapping handshake counter. Outputs come straight from registers.
module demux_n_1_2 #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_n_1_2_if.slave  bus
);

  logic [1:0]    push;
  logic [1:0]    out_ready_w;
  logic [1:0]    full_w;
  logic [1:0]    valid_w;
  logic          in_ready_w;
  logic [N-1:0]  head_w [2];
  logic [CW-1:0] xfer_w [2];

  assign out_ready_w = {bus.out_ready_1, bus.out_ready_0};

  // Readiness looks only at the selected buffer's registered occupancy.
  assign in_ready_w   = bus.sel ? !full_w[1] : !full_w[0];
  assign bus.in_ready = in_ready_w;
  assign push[0]      = bus.in_valid && in_ready_w && !bus.sel;
  assign push[1]      = bus.in_valid && in_ready_w &&  bus.sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      logic [N-1:0]  mem_q [2];
      logic          rd_ptr_q, rd_ptr_d;
      logic [1:0]    cnt_q, cnt_d;
      logic [CW-1:0] xfer_q, xfer_d;
      logic          pop;
      logic          wr_ptr;

      assign pop = (cnt_q != 2'd0) && out_ready_w[gi];
      // A push only happens with cnt 0 or 1, so the low count bit picks the free slot.
      assign wr_ptr = rd_ptr_q ^ cnt_q[0];

      always_comb begin
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        xfer_d   = xfer_q;
        if (pop) begin
          rd_ptr_d = ~rd_ptr_q;
          xfer_d   = xfer_q + CW'(1);
        end
        case ({push[gi], pop})
          2'b10:   cnt_d = cnt_q + 2'd1;
          2'b01:   cnt_d = cnt_q - 2'd1;
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[0] <= '0;
          mem_q[1] <= '0;
          rd_ptr_q <= 1'b0;
          cnt_q    <= 2'd0;
          xfer_q   <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
          xfer_q   <= xfer_d;
          if (push[gi]) begin
            mem_q[wr_ptr] <= bus.in_0;
          end
        end
      end

      assign head_w[gi]  = mem_q[rd_ptr_q];
      assign valid_w[gi] = (cnt_q != 2'd0);
      assign full_w[gi]  = (cnt_q == 2'd2);
      assign xfer_w[gi]  = xfer_q;
    end
  endgenerate

  assign bus.out_y_0     = head_w[0];
  assign bus.out_y_1     = head_w[1];
  assign bus.out_valid_0 = valid_w[0];
  assign bus.out_valid_1 = valid_w[1];
  assign bus.xfer_cnt_0  = xfer_w[0];
  assign bus.xfer_cnt_1  = xfer_w[1];

endmodule
